// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame edge numbering and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam int DATA_BITS          = 8;
    localparam int STOP_EDGE          = 10;
    localparam int ACK_EDGE           = 11;
    localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between a host controller and ps2_host_tx.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;
    logic                 ack_ok;
    logic                 err;

    modport master (output tx_valid, tx_data, input tx_ready, busy, done, ack_ok, err);
    modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, ack_ok, err);
endinterface

// File: rtl/ps2_sync.sv
// PS/2 pin synchroniser with ps2_clk falling-edge detect; shared with the receiver.
module ps2_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_clk_s,
    output logic o_data_s,
    output logic o_fall
);
    logic [2:0] r_clk_sync;
    logic [1:0] r_data_sync;

    // Reset to the idle-high bus level so release of reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_clk_raw};
            r_data_sync <= {r_data_sync[0], i_data_raw};
        end
    end

    assign o_clk_s  = r_clk_sync[1];
    assign o_data_s = r_data_sync[1];
    assign o_fall   = r_clk_sync[2] & ~r_clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave tx
);
    localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ICW-1:0] INH_LAST   = ICW'(INHIBIT_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_MAX    = TCW'(TIMEOUT_CYCLES);
    localparam logic [3:0]     SHIFT_LIM  = 4'(DATA_BITS + 1);
    localparam logic [3:0]     STOP_PREV  = 4'(STOP_EDGE - 1);

    ps2_state_t         r_state;
    ps2_state_t         w_state_next;
    logic [DATA_BITS:0] r_shift;
    logic [3:0]         r_bitcnt;
    logic [ICW-1:0]     r_icnt;
    logic [TCW-1:0]     r_tcnt;
    logic               r_data_oe;
    logic               r_done;
    logic               r_ack_ok;
    logic               r_err;

    logic               w_clk_s;
    logic               w_data_s;
    logic               w_fall;
    logic               w_accept;
    logic               w_timeout;
    logic               w_bus_idle;
    logic [TCW-1:0]     w_tcnt_inc;

    ps2_sync u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .i_clk_raw  (ps2_clk_i),
        .i_data_raw (ps2_data_i),
        .o_clk_s    (w_clk_s),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    assign w_accept   = tx.tx_valid && (r_state == ST_IDLE);
    assign w_bus_idle = w_clk_s && w_data_s;
    assign w_timeout  = ((r_state == ST_SEND) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE))
                        && (r_tcnt == TMO_MAX);
    assign w_tcnt_inc = (r_tcnt == TMO_MAX) ? r_tcnt : r_tcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Timeout is tested before the fall so it wins when both land on the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_next = ST_INHIBIT;
            ST_INHIBIT:   if (r_icnt == INH_LAST) w_state_next = ST_REQ;
            ST_REQ:       w_state_next = ST_SEND;
            ST_SEND: begin
                if (w_timeout)                             w_state_next = ST_IDLE;
                else if (w_fall && (r_bitcnt == STOP_PREV)) w_state_next = ST_ACK;
            end
            ST_ACK: begin
                if (w_timeout)   w_state_next = ST_IDLE;
                else if (w_fall) w_state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE:  if (w_timeout || w_bus_idle) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
        ps2_data_oe = 1'b0;
        if (r_state == ST_REQ)       ps2_data_oe = 1'b1;
        else if (r_state == ST_SEND) ps2_data_oe = r_data_oe;
        tx.tx_ready = (r_state == ST_IDLE);
        tx.busy     = (r_state != ST_IDLE);
    end

    assign tx.done   = r_done;
    assign tx.ack_ok = r_ack_ok;
    assign tx.err    = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_icnt    <= '0;
            r_tcnt    <= '0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_timeout) begin
                r_data_oe <= 1'b0;
                r_done    <= 1'b1;
                r_ack_ok  <= 1'b0;
                r_err     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_accept) begin
                        r_shift  <= {odd_parity(tx.tx_data), tx.tx_data};
                        r_icnt   <= '0;
                        r_ack_ok <= 1'b0;
                        r_err    <= 1'b0;
                    end
                    ST_INHIBIT: r_icnt <= r_icnt + 1'b1;
                    ST_REQ: begin
                        r_bitcnt  <= '0;
                        r_tcnt    <= '0;
                        r_data_oe <= 1'b1;
                    end
                    ST_SEND: begin
                        if (w_fall) begin
                            r_tcnt   <= '0;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt < SHIFT_LIM) begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= r_shift >> 1;
                            end else begin
                                r_data_oe <= 1'b0;
                            end
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    ST_ACK: begin
                        if (w_fall) begin
                            r_tcnt   <= '0;
                            r_bitcnt <= 4'(ACK_EDGE);
                            r_ack_ok <= ~w_data_s;
                            r_err    <= w_data_s;
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_bus_idle) r_done <= 1'b1;
                        else if (w_fall) r_tcnt <= '0;
                        else r_tcnt <= w_tcnt_inc;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model clocking at a 20-cycle period.
module tb_ps2_host_tx;
    localparam int INH = 4;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic clk_line, data_line;

    always #5 clk = ~clk;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_if txif ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx          (txif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int acc_at_done = 0;
    int ready_hits = 0;
    int oe_hits = 0;
    bit mon_ready_en = 0;
    bit mon_oe_en = 0;
    logic done_ack = 1'b0;
    logic done_err = 1'b0;
    logic [1:0] done_oe = 2'b00;
    logic [11:0] bits;

    // Passive monitor, sampled 1 ns after the falling edge once the bench's drives have settled.
    always @(negedge clk) begin
        #1;
        if (txif.done === 1'b1) begin
            done_cnt++;
            acc_at_done = acc_cnt;
            done_ack = txif.ack_ok;
            done_err = txif.err;
            done_oe  = {ps2_clk_oe, ps2_data_oe};
        end
        if (resetn && txif.tx_valid && txif.tx_ready) acc_cnt++;
        if (mon_ready_en && txif.tx_ready && !txif.done) ready_hits++;
        if (mon_oe_en && (ps2_clk_oe || ps2_data_oe)) oe_hits++;
    end

    task automatic wait_send(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txif.busy && !ps2_clk_oe && ps2_data_oe) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int exp_cnt, input int limit, output int waited);
        waited = 0;
        while (done_cnt < exp_cnt && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // One device clock: low 10 cycles (host data sampled at the end), high 10 cycles.
    task automatic dev_fall(input int k, input bit drive_low);
        @(negedge clk);
        dev_clk_low  = 1'b1;
        dev_data_low = drive_low;
        repeat (9) @(negedge clk);
        bits[k] = data_line;
        @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic dev_frame(input int n, input bit ack);
        bits = '1;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= n; k++) dev_fall(k, ack && (k == 11));
    endtask

    task automatic start_tx(input logic [7:0] b, output bit ok);
        @(negedge clk);
        txif.tx_valid = 1'b1;
        txif.tx_data  = b;
        @(negedge clk);
        txif.tx_valid = 1'b0;
        wait_send(ok);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe, txif.done, txif.ack_ok, txif.err, txif.busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 000000", {ps2_clk_oe, ps2_data_oe, txif.done, txif.ack_ok, txif.err, txif.busy});
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (txif.tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 1", txif.tx_ready);
        end
        $display("reset: outputs idle, tx_ready=%b", txif.tx_ready);
    endtask

    task automatic test_send_ed();
        int n_inh;
        int w;
        int d0 = done_cnt;
        @(negedge clk);
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'hED;
        @(negedge clk);
        txif.tx_valid = 1'b0;
        n_inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && n_inh < 50) begin
            n_inh++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_inh !== 4) begin n_bad++; $display("FAIL ed_inhibit_len: got %0d required 4", n_inh); end
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin n_bad++; $display("FAIL ed_req: got %b required 11", {ps2_clk_oe, ps2_data_oe}); end
        @(negedge clk);
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin n_bad++; $display("FAIL ed_start: got %b required 01", {ps2_clk_oe, ps2_data_oe}); end
        dev_frame(11, 1'b1);
        n_cmp++;
        if (bits[8:1] !== 8'b1110_1101) begin n_bad++; $display("FAIL ed_data: got %b required 11101101", bits[8:1]); end
        n_cmp++;
        if (bits[10:9] !== 2'b11) begin n_bad++; $display("FAIL ed_parity_stop: got %b required 11", bits[10:9]); end
        wait_done(d0 + 1, 50, w);
        n_cmp++;
        if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL ed_done: got %0d pulses required 1", done_cnt - d0); end
        n_cmp++;
        if ({done_ack, done_err} !== 2'b10) begin n_bad++; $display("FAIL ed_ack: got ack_ok/err %b required 10", {done_ack, done_err}); end
        $display("tx 0xED: data=%b par=%b ack_ok=%b err=%b", bits[8:1], bits[9], done_ack, done_err);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int w;
        int d0 = done_cnt;
        int a0 = acc_cnt;
        @(negedge clk);
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'hF4;
        @(negedge clk);
        txif.tx_data = 8'h00;
        ready_hits   = 0;
        mon_ready_en = 1;
        wait_send(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_send1: got %b required 1", ok); end
        dev_frame(11, 1'b1);
        n_cmp++;
        if (bits[9:1] !== 9'b0_1111_0100) begin n_bad++; $display("FAIL b2b_f4_frame: got %b required 011110100", bits[9:1]); end
        wait_done(d0 + 1, 50, w);
        mon_ready_en = 0;
        n_cmp++;
        if (ready_hits !== 0) begin n_bad++; $display("FAIL b2b_ready_busy: got %0d ready cycles required 0", ready_hits); end
        n_cmp++;
        if (acc_at_done - a0 !== 1) begin n_bad++; $display("FAIL b2b_accept_order: got %0d accepts before done required 1", acc_at_done - a0); end
        $display("tx 0xF4: data=%b par=%b ack_ok=%b err=%b", bits[8:1], bits[9], done_ack, done_err);
        wait_send(ok);
        txif.tx_valid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_send2: got %b required 1", ok); end
        dev_frame(11, 1'b1);
        n_cmp++;
        if (bits[9:1] !== 9'b1_0000_0000) begin n_bad++; $display("FAIL b2b_00_frame: got %b required 100000000", bits[9:1]); end
        wait_done(d0 + 2, 50, w);
        n_cmp++;
        if ({done_cnt - d0, done_ack, done_err} !== {32'd2, 2'b10}) begin
            n_bad++;
            $display("FAIL b2b_done2: got %0d pulses ack_ok/err %b required 2 and 10", done_cnt - d0, {done_ack, done_err});
        end
        $display("tx 0x00: data=%b par=%b ack_ok=%b err=%b", bits[8:1], bits[9], done_ack, done_err);
    endtask

    task automatic test_no_ack();
        bit ok;
        int w;
        int d0 = done_cnt;
        start_tx(8'hFF, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL nack_send: got %b required 1", ok); end
        dev_frame(11, 1'b0);
        n_cmp++;
        if (bits[10:1] !== 10'b11_1111_1111) begin n_bad++; $display("FAIL nack_frame: got %b required 1111111111", bits[10:1]); end
        wait_done(d0 + 1, 50, w);
        n_cmp++;
        if ({done_cnt - d0, done_ack, done_err} !== {32'd1, 2'b01}) begin
            n_bad++;
            $display("FAIL nack_result: got %0d pulses ack_ok/err %b required 1 and 01", done_cnt - d0, {done_ack, done_err});
        end
        $display("tx 0xFF: data=%b par=%b ack_ok=%b err=%b", bits[8:1], bits[9], done_ack, done_err);
    endtask

    task automatic test_timeout();
        bit ok;
        int w;
        int d0 = done_cnt;
        start_tx(8'hA5, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL tmo_send: got %b required 1", ok); end
        dev_frame(5, 1'b0);
        wait_done(d0 + 1, 400, w);
        n_cmp++;
        if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL tmo_done: got %0d pulses required 1", done_cnt - d0); end
        n_cmp++;
        if (w < 180 || w > 195) begin n_bad++; $display("FAIL tmo_delay: got %0d cycles after last fall+19 required 180..195", w); end
        n_cmp++;
        if ({done_oe, done_ack, done_err} !== 4'b0001) begin
            n_bad++;
            $display("FAIL tmo_result: got oe=%b ack_ok/err=%b required oe=00 ack_ok/err=01", done_oe, {done_ack, done_err});
        end
        $display("tx 0xA5: timeout after %0d cycles, ack_ok=%b err=%b", w, done_ack, done_err);
        d0 = done_cnt;
        start_tx(8'h3C, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL tmo_next_accept: got %b required 1", ok); end
        dev_frame(11, 1'b1);
        wait_done(d0 + 1, 50, w);
        n_cmp++;
        if ({done_cnt - d0, done_ack, done_err} !== {32'd1, 2'b10}) begin
            n_bad++;
            $display("FAIL tmo_next_result: got %0d pulses ack_ok/err %b required 1 and 10", done_cnt - d0, {done_ack, done_err});
        end
        $display("tx 0x3C: data=%b par=%b ack_ok=%b err=%b", bits[8:1], bits[9], done_ack, done_err);
    endtask

    task automatic test_idle_falls();
        int d0 = done_cnt;
        oe_hits   = 0;
        mon_oe_en = 1;
        bits      = '1;
        for (int k = 1; k <= 3; k++) dev_fall(k, 1'b0);
        repeat (3) @(negedge clk);
        mon_oe_en = 0;
        n_cmp++;
        if (oe_hits !== 0) begin n_bad++; $display("FAIL idle_oe: got %0d active cycles required 0", oe_hits); end
        n_cmp++;
        if ({done_cnt - d0, 31'd0, txif.busy} !== 64'd0) begin
            n_bad++;
            $display("FAIL idle_done_busy: got %0d pulses busy=%b required 0 and 0", done_cnt - d0, txif.busy);
        end
        $display("idle falls: oe cycles=%0d done pulses=%0d", oe_hits, done_cnt - d0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        start_tx(8'h5A, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_send: got %b required 1", ok); end
        bits = '1;
        repeat (4) @(negedge clk);
        dev_fall(1, 1'b0);
        dev_fall(2, 1'b0);
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin n_bad++; $display("FAIL rst_bit3_drive: got %b required 01", {ps2_clk_oe, ps2_data_oe}); end
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL rst_release: got %b required 00", {ps2_clk_oe, ps2_data_oe}); end
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({txif.tx_ready, txif.busy} !== 2'b10) begin n_bad++; $display("FAIL rst_ready: got ready/busy %b required 10", {txif.tx_ready, txif.busy}); end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_cnt !== d0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses required 0", done_cnt - d0); end
        $display("tx 0x5A: reset during bit 3, done pulses=%0d", done_cnt - d0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        txif.tx_valid = 1'b0;
        txif.tx_data  = 8'h00;
        bits = '1;
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_no_ack();
        test_timeout();
        test_idle_falls();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. LED set 0xED, enable 0xF4) to the attached keyboard over the shared open-drain ps2_clk/ps2_data lines, then checks the device ACK bit. It sits beside the existing PS/2 receiver on the same pins. The receiver continues to handle device-to-host traffic; this block owns the bus only while a command is in flight.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles allowed between consecutive device falling edges, and in WAIT_IDLE (15 ms at 50 MHz)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
ps2_clk_i  in  1  raw PS/2 clock pin level (asynchronous)
ps2_data_i  in  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release (pulled high)
ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release
tx_valid  in  1  command byte available
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid & tx_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a transfer ends (success or failure)
ack_ok  out  1  valid with done: device drove ACK low
err  out  1  valid with done: timeout, or ACK bit sampled high

Behaviour:
- Reset: clock and reset are clk and resetn (synchronous, active-low). On reset, state=IDLE; ps2_clk_oe, ps2_data_oe, done, ack_ok and err are 0; busy=0; tx_ready=1 one cycle after reset deasserts. Reset mid-transfer releases both lines immediately at the reset edge and produces no done pulse.
- Input sync: ps2_clk_i passes through a 3-flop shift; fall = sync[2] & ~sync[1]. ps2_data_i is synchronised through 2 flops. All sampling uses the synced values.
- Accept: on tx_valid & tx_ready, latch shift[8:0] = {~^tx_data, tx_data}. This gives odd parity. Go to INHIBIT. tx_valid is ignored while busy.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit 0) for 1 cycle, then go to SEND with clk_oe=0 and data_oe held at 1. Clear bitcnt and the timeout counter.
- SEND: on each fall, bitcnt++.
  - Edges 1..9: data_oe = ~shift[0], then shift >>= 1. Data bits go out LSB first, parity on edge 9.
  - Edge 10: data_oe=0 (stop bit 1, line released). Go to ACK.
- ACK: on the next fall (edge 11), sample synced data. 0 means ack_ok=1, err=0; 1 means ack_ok=0, err=1. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1 on the same cycle. Then pulse done for 1 cycle and go to IDLE. ack_ok and err hold their values until the next accept, which clears both.
- Timeout: the counter clears on every fall and on entry to each of SEND, ACK and WAIT_IDLE. If it reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE:
  - release both lines
  - done=1 for 1 cycle, err=1, ack_ok=0
  - go to IDLE
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- A fall occurring on the same cycle the timeout is reached: the timeout wins.
- Falls seen in IDLE, INHIBIT or REQ are ignored; device traffic in those states belongs to the receiver. The inhibit intentionally aborts any in-progress device frame.
- Latency from accept to data_oe first change: INHIBIT_CYCLES+1 cycles.

Decomposition:
- ps2_pkg: state encodings (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE), frame constants (DATA_BITS=8, STOP_EDGE=10, ACK_EDGE=11), default timing values.
- Sub-module ps2_sync: synchroniser plus falling-edge detector, shared with the receiver.

Test Plan:
Use INHIBIT_CYCLES=4 and TIMEOUT_CYCLES=200 for all scenarios. The device model clocks at a 20-cycle period and drives the ACK low unless stated.
1. Send 0xED. Required: clk held low exactly 4 cycles, then start 0. Data bits on falls 1-8 are 1,0,1,1,0,1,1,1; parity 1 on fall 9; line released on fall 10. Device ACK low gives done pulse with ack_ok=1, err=0.
2. Send 0xF4, then 0x00 back-to-back with tx_valid held high. Required: parity 0 then 1; second accept only after done; tx_ready=0 throughout the first transfer.
3. Send 0xFF with the model never driving the ACK low. Required: done with ack_ok=0, err=1.
4. The model stops clocking after fall 5. Required: 200 cycles later both oe=0 and done with err=1; next tx_valid is accepted.
5. Assert resetn=0 during SEND bit 3. Required: both oe=0 at the reset edge, no done pulse, tx_ready=1 after release.
6. Inject device falls while IDLE. Required: no oe activity and no done pulse.
